// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with parallel load, shift counter and done pulse
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [1:0]                 MODE,
  input  logic [WIDTH-1:0]           D,
  input  logic                       SIN_MSB,
  input  logic                       SIN_LSB,
  output logic [WIDTH-1:0]           Q,
  output logic                       SOUT_LSB,
  output logic                       SOUT_MSB,
  output logic [$clog2(WIDTH+1)-1:0] CNT,
  output logic                       DONE
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  assign SOUT_LSB = Q[0];
  assign SOUT_MSB = Q[WIDTH-1];

  // DONE defaults low every edge so the pulse is one cycle wide even across EN stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q    <= RESET_VAL;
      CNT  <= '0;
      DONE <= 1'b0;
    end else if (!EN) begin
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (MODE)
        MODE_HOLD: begin
        end
        MODE_RIGHT, MODE_LEFT: begin
          if (MODE == MODE_RIGHT) Q <= {SIN_MSB, Q[WIDTH-1:1]};
          else                    Q <= {Q[WIDTH-2:0], SIN_LSB};
          // Counter saturates at WIDTH; only the WIDTH-1 -> WIDTH step raises DONE.
          if (CNT != CNT_MAX) begin
            CNT  <= CNT + 1'b1;
            DONE <= (CNT == CNT_MAX - 1'b1);
          end
        end
        MODE_LOAD: begin
          Q   <= D;
          CNT <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg at WIDTH=8, RESET_VAL=0
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, EN, SIN_MSB, SIN_LSB;
  logic [1:0]   MODE;
  logic [W-1:0] D, Q;
  logic         SOUT_LSB, SOUT_MSB, DONE;
  logic [3:0]   CNT;

  typedef struct packed {
    logic [W-1:0] q;
    logic [3:0]   cnt;
    logic         done;
    logic         sout_lsb;
    logic         sout_msb;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];

  logic [W-1:0] m_q;
  logic [3:0]   m_cnt;
  logic         m_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D),
    .SIN_MSB(SIN_MSB), .SIN_LSB(SIN_LSB), .Q(Q),
    .SOUT_LSB(SOUT_LSB), .SOUT_MSB(SOUT_MSB), .CNT(CNT), .DONE(DONE)
  );

  // Drive one cycle, predict the post-edge state, push prediction and observation.
  task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                       input logic [W-1:0] d, input logic smsb, input logic slsb);
    obs_t e, a;
    RST = rst; EN = en; MODE = mode; D = d; SIN_MSB = smsb; SIN_LSB = slsb;
    if (rst) begin
      m_q = 8'h00; m_cnt = 4'd0; m_done = 1'b0;
    end else if (!en) begin
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (mode == 2'b01) m_q = {smsb, m_q[W-1:1]};
      if (mode == 2'b10) m_q = {m_q[W-2:0], slsb};
      if (mode == 2'b11) begin m_q = d; m_cnt = 4'd0; end
      if (mode == 2'b01 || mode == 2'b10) begin
        if (m_cnt == 4'd7) m_done = 1'b1;
        if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1;
      end
    end
    e.q = m_q; e.cnt = m_cnt; e.done = m_done; e.sout_lsb = m_q[0]; e.sout_msb = m_q[W-1];
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    a.q = Q; a.cnt = CNT; a.done = DONE; a.sout_lsb = SOUT_LSB; a.sout_msb = SOUT_MSB;
    act_q.push_back(a);
  endtask

  task automatic test_reset();
    obs_t e, a;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1);
    n_checks++;
    if (Q !== 8'h00 || CNT !== 4'd0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL reset_final: got q=%h cnt=%0d done=%b, need q=00 cnt=0 done=0", Q, CNT, DONE);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL reset_sb: got %h need %h", a, e); end
    end
  endtask

  task automatic test_shift_right();
    obs_t e, a;
    logic [W-1:0] pat;
    pat = 8'hA5;
    drive(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (SOUT_LSB !== pat[i]) begin
        n_fail++; $display("FAIL right_sout_lsb[%0d]: got %b need %b", i, SOUT_LSB, pat[i]);
      end
      drive(1'b0, 1'b1, 2'b01, 'x, 1'b0, 1'b1);
    end
    n_checks++;
    if (Q !== 8'h00 || CNT !== 4'd8 || DONE !== 1'b1) begin
      n_fail++; $display("FAIL right_final: got q=%h cnt=%0d done=%b, need q=00 cnt=8 done=1", Q, CNT, DONE);
    end
    drive(1'b0, 1'b1, 2'b00, 8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (DONE !== 1'b0 || CNT !== 4'd8) begin
      n_fail++; $display("FAIL right_done_width: got done=%b cnt=%0d, need done=0 cnt=8", DONE, CNT);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL right_sb: got %h need %h", a, e); end
    end
  endtask

  task automatic test_shift_left();
    obs_t e, a;
    drive(1'b0, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b10, 'x, 1'b0, 1'b1);
    n_checks++;
    if (Q !== 8'h0F || CNT !== 4'd3 || SOUT_MSB !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL left_final: got q=%h cnt=%0d msb=%b done=%b, need q=0f cnt=3 msb=0 done=0",
                         Q, CNT, SOUT_MSB, DONE);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL left_sb: got %h need %h", a, e); end
    end
  endtask

  task automatic test_en_stall();
    obs_t e, a;
    int dones;
    dones = 0;
    drive(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 2'b01, 'x, 1'b0, 1'b0); dones += int'(DONE); end
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1); dones += int'(DONE); end
    n_checks++;
    if (Q !== 8'h20 || CNT !== 4'd2) begin
      n_fail++; $display("FAIL stall_frozen: got q=%h cnt=%0d, need q=20 cnt=2", Q, CNT);
    end
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 2'b01, 'x, 1'b0, 1'b0); dones += int'(DONE); end
    n_checks++;
    if (Q !== 8'h08 || CNT !== 4'd4 || dones != 0) begin
      n_fail++; $display("FAIL stall_final: got q=%h cnt=%0d dones=%0d, need q=08 cnt=4 dones=0", Q, CNT, dones);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL stall_sb: got %h need %h", a, e); end
    end
  endtask

  task automatic test_saturate();
    obs_t e, a;
    logic [W-1:0] q_before;
    drive(1'b0, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 'x, i[0], i[1]);
    n_checks++;
    if (CNT !== 4'd8 || DONE !== 1'b1) begin
      n_fail++; $display("FAIL sat_reach: got cnt=%0d done=%b, need cnt=8 done=1", CNT, DONE);
    end
    for (int i = 0; i < 3; i++) begin
      q_before = Q;
      drive(1'b0, 1'b1, 2'b10, 'x, 1'b0, 1'b1);
      n_checks++;
      if (CNT !== 4'd8 || DONE !== 1'b0 || Q !== {q_before[W-2:0], 1'b1}) begin
        n_fail++; $display("FAIL sat_extra[%0d]: got q=%h cnt=%0d done=%b, need q=%h cnt=8 done=0",
                           i, Q, CNT, DONE, {q_before[W-2:0], 1'b1});
      end
    end
    drive(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (Q !== 8'h3C || CNT !== 4'd0) begin
      n_fail++; $display("FAIL sat_reload: got q=%h cnt=%0d, need q=3c cnt=0", Q, CNT);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL sat_sb: got %h need %h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, a;
    int dones, done_at;
    dones = 0; done_at = -1;
    drive(1'b0, 1'b1, 2'b11, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'b01, 'x, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1);
    n_checks++;
    if (Q !== 8'h00 || CNT !== 4'd0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got q=%h cnt=%0d done=%b, need q=00 cnt=0 done=0", Q, CNT, DONE);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 2'b10, 'x, 1'b0, 1'b1);
      if (DONE === 1'b1) begin dones++; done_at = i; end
    end
    n_checks++;
    if (dones != 1 || done_at != 7) begin
      n_fail++; $display("FAIL mid_done: got pulses=%0d at=%0d, need pulses=1 at=7", dones, done_at);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL mid_sb: got %h need %h", a, e); end
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; MODE = 2'b11; D = 8'hFF; SIN_MSB = 1'b0; SIN_LSB = 1'b0;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_en_stall();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
